// File: rtl/seg7_scan_ctrl.sv
// Press counter with debounced button, N-digit BCD count and a scan
// scheduler sharing one BCD-to-7-seg decoder across all display digits.
//
// Ports:
//   clk, rst      rising-edge clock, async active-high reset
//   button        raw push button, pressed = 0
//   enable        0 clears the count and blanks the display
//   seg7all_on    lamp test: all digits on, count frozen
//   bcd_out       nibble for the shared decoder
//   dec_enable    decoder enable (registered)
//   dec_all_on    decoder lamp test (registered)
//   dig_en        active-high digit selects
//   count_bcd     full BCD count, digit 0 in [3:0]
//   press_evt     one-cycle pulse per accepted press
module seg7_scan_ctrl #(
  parameter int N_DIGITS  = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int GHOST_CYC = 8,
  parameter int DEB_CYC   = 250000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  button,
  input  logic                  enable,
  input  logic                  seg7all_on,
  output logic [3:0]            bcd_out,
  output logic                  dec_enable,
  output logic                  dec_all_on,
  output logic [N_DIGITS-1:0]   dig_en,
  output logic [4*N_DIGITS-1:0] count_bcd,
  output logic                  press_evt
);

  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [1:0]    btn_sync;
  logic [1:0]    en_sync;
  logic [1:0]    all_sync;
  logic          btn_s;
  logic          en_s;
  logic          all_s;
  logic          btn_st;
  logic [DW-1:0] deb_cnt;
  logic          deb_done;
  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] dig_idx;
  logic [4*N_DIGITS-1:0] count_inc;
  logic          carry;

  assign btn_s = btn_sync[1];
  assign en_s  = en_sync[1];
  assign all_s = all_sync[1];

  // Button synchroniser idles at the released level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_sync <= 2'b11;
      en_sync  <= 2'b00;
      all_sync <= 2'b00;
    end else begin
      btn_sync <= {btn_sync[0], button};
      en_sync  <= {en_sync[0], enable};
      all_sync <= {all_sync[0], seg7all_on};
    end
  end

  assign deb_done = (btn_s != btn_st) &&
                    (deb_cnt == DW'(DEB_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_st    <= 1'b1;
      deb_cnt   <= '0;
      press_evt <= 1'b0;
    end else begin
      press_evt <= deb_done && btn_st;
      if (btn_s == btn_st) begin
        deb_cnt <= '0;
      end else if (deb_done) begin
        btn_st  <= btn_s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // Ripple decimal increment: a digit steps only while all
  // lower digits are rolling over from 9.
  always_comb begin
    count_inc = count_bcd;
    carry     = 1'b1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (carry) begin
        if (count_bcd[4*k +: 4] == 4'd9) begin
          count_inc[4*k +: 4] = 4'd0;
        end else begin
          count_inc[4*k +: 4] = count_bcd[4*k +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_bcd <= '0;
    end else if (!en_s) begin
      count_bcd <= '0;
    end else if (all_s) begin
      count_bcd <= count_bcd;
    end else if (press_evt) begin
      count_bcd <= count_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      if (dig_idx == IW'(N_DIGITS - 1)) begin
        dig_idx <= '0;
      end else begin
        dig_idx <= dig_idx + 1'b1;
      end
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // bcd_out lags dig_idx by one cycle; the ghost gap at the
  // start of every slot hides that stale cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_out    <= 4'd0;
      dec_enable <= 1'b0;
      dec_all_on <= 1'b0;
    end else begin
      bcd_out    <= count_bcd[4*dig_idx +: 4];
      dec_enable <= en_s;
      dec_all_on <= all_s;
    end
  end

  always_comb begin
    dig_en = '0;
    if (dec_enable && dec_all_on) begin
      dig_en = '1;
    end else if (dec_enable &&
                 scan_cnt >= SW'(GHOST_CYC)) begin
      dig_en[dig_idx] = 1'b1;
    end
  end

endmodule
